// File: rtl/instr_mem_loader.sv
// Boot-time loader: packs a high-byte-first byte stream into 16-bit words and writes them to instruction memory from address 0.
// Latency: one word per HI/LO/WR sequence (3 cycles minimum); Mem_Write is high the cycle after the low byte transfers.
// Backpressure: Byte_Ready is high only in HI/LO; bytes offered in IDLE/WR/DONE are left unconsumed.
module instr_mem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [6:0]        Num_Words,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_Write,
  output logic              Cpu_Hold,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [6:0] DEPTH_W = 7'(DEPTH);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [6:0]        r_count;
  logic [6:0]        r_num;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_error;

  logic              w_xfer;
  logic              w_start_ok;
  logic [6:0]        w_count_inc;

  assign Byte_Ready  = (r_state == S_HI) || (r_state == S_LO);
  assign w_xfer      = Byte_Valid && Byte_Ready;
  assign w_start_ok  = (Num_Words != 7'd0) && (Num_Words <= DEPTH_W);
  assign w_count_inc = r_count + 7'd1;

  assign Mem_Write = (r_state == S_WR);
  assign Done      = (r_state == S_DONE);
  assign Mem_Addr  = r_addr;
  assign Mem_Data  = r_data;
  assign Busy      = r_busy;
  assign Cpu_Hold  = r_busy;
  assign Error     = r_error;

  // Next-state selection; each byte state waits indefinitely for its transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Start && w_start_ok) w_next = S_HI;
      S_HI:   if (w_xfer) w_next = S_LO;
      S_LO:   if (w_xfer) w_next = S_WR;
      S_WR:   w_next = (w_count_inc == r_num) ? S_DONE : S_HI;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus the busy flag, which tracks "not going back to IDLE".
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Word counter and latched load length; the counter advances once per write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count <= 7'd0;
      r_num   <= 7'd0;
    end else if (r_state == S_IDLE && Start && w_start_ok) begin
      r_count <= 7'd0;
      r_num   <= Num_Words;
    end else if (r_state == S_WR) begin
      r_count <= w_count_inc;
    end
  end

  // Data/address capture; both hold between writes so they are stable during the WR strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data <= '0;
      r_addr <= '0;
    end else if (w_xfer && r_state == S_HI) begin
      r_data[15:8] <= Byte_In;
    end else if (w_xfer && r_state == S_LO) begin
      r_data[7:0] <= Byte_In;
      r_addr      <= ADDR_W'(r_count);
    end
  end

  // One-cycle rejection pulse for a zero or oversized load request.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_error <= 1'b0;
    end else begin
      r_error <= (r_state == S_IDLE) && Start && !w_start_ok;
    end
  end

endmodule
